// File: rtl/mips_pkg.sv
// mips_pkg
// Shared types and constants for the MIPS instruction-fetch slice.
//   fetch_state_t : LOAD (program loading), RUN (fetching), HALT (stopped on NOPs)
//   INSTR_W       : instruction word width
//   MIPS_NOP      : encoding of the all-zero NOP (sll $0,$0,0)
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_LOAD = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W  = 32;
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_imem_fetch_imem_byte_ram.sv
// imem_byte_ram
// Byte-organised instruction storage with one byte write port and a
// combinational little-endian 32-bit word read at any byte address.
// Ports:
//   clk, reset          : clock, asynchronous active-high clear of every byte
//   wr_en/wr_addr/wr_data : byte write on rising edge
//   rd_addr             : byte address of the word to read
//   rd_word             : {mem[a+3], mem[a+2], mem[a+1], mem[a]}
module imem_byte_ram
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256,
    parameter int ADDR_W     = $clog2(IMEM_BYTES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [7:0]         wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_word
);

    logic [7:0]        mem [IMEM_BYTES];
    logic [ADDR_W-1:0] addr_1;
    logic [ADDR_W-1:0] addr_2;
    logic [ADDR_W-1:0] addr_3;

    // Reset wipes the whole program so a stale image can never be fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Byte offsets wrap naturally because they are kept at ADDR_W bits.
    always_comb begin
        addr_1  = rd_addr + ADDR_W'(1);
        addr_2  = rd_addr + ADDR_W'(2);
        addr_3  = rd_addr + ADDR_W'(3);
        rd_word = {mem[addr_3], mem[addr_2], mem[addr_1], mem[rd_addr]};
    end

endmodule

// File: rtl/mips_imem_fetch.sv
// mips_imem_fetch
// Instruction memory plus fetch sequencer. A loader writes program bytes while
// the block is in LOAD or HALT; start begins fetching at RESET_PC and words are
// handed to decode over a valid/ready pair, one per cycle under continuous
// ready. A redirect flushes the presented word and refetches from the target.
// NOP_HALT_COUNT consecutive accepted NOPs stop fetching (HALT).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   load_en/load_addr/load_data     : byte loader (ignored while running)
//   start                           : leave LOAD/HALT and fetch from RESET_PC
//   instr_out/instr_pc/instr_valid  : presented word, its byte address, valid
//   instr_ready                     : decode accepts when valid & ready
//   redirect_en/redirect_pc         : branch/jump target (word aligned)
//   running/halted                  : state is RUN / HALT
//   load_err                        : one-cycle pulse for a load seen in RUN
module mips_imem_fetch
    import mips_pkg::*;
#(
    parameter int                IMEM_BYTES     = 256,
    parameter int                ADDR_W         = $clog2(IMEM_BYTES),
    parameter int                NOP_HALT_COUNT = 3,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [7:0]         load_data,
    input  logic               start,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               running,
    output logic               halted,
    output logic               load_err
);

    localparam int              NOP_W    = $clog2(NOP_HALT_COUNT + 1);
    localparam logic [NOP_W-1:0] NOP_MAX  = NOP_W'(NOP_HALT_COUNT);
    localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(NOP_HALT_COUNT - 1);

    fetch_state_t       state;
    fetch_state_t       state_n;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_n;
    logic [NOP_W-1:0]   nop_cnt;
    logic [NOP_W-1:0]   nop_n;
    logic [INSTR_W-1:0] out_n;
    logic [ADDR_W-1:0]  out_pc_n;
    logic               valid_n;
    logic               load_err_n;

    logic               accept;
    logic               wr_en;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_word;

    assign accept   = instr_valid & instr_ready;
    assign pc_plus4 = pc + ADDR_W'(4);
    assign wr_en    = load_en & (state != FETCH_RUN);
    assign running  = (state == FETCH_RUN);
    assign halted   = (state == FETCH_HALT);

    // On an accept the next word is read one slot ahead so there is no bubble;
    // otherwise the RAM looks at pc itself (empty refill after start/redirect).
    assign rd_addr  = (state == FETCH_RUN && !redirect_en && accept) ? pc_plus4 : pc;

    imem_byte_ram #(
        .IMEM_BYTES (IMEM_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_word (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH_LOAD;
            pc          <= RESET_PC;
            nop_cnt     <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            nop_cnt     <= nop_n;
            instr_out   <= out_n;
            instr_pc    <= out_pc_n;
            instr_valid <= valid_n;
            load_err    <= load_err_n;
        end
    end

    // Redirect outranks accept: the flushed word may still be consumed by
    // decode, but pc follows the target and the NOP run is broken.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        nop_n      = nop_cnt;
        out_n      = instr_out;
        out_pc_n   = instr_pc;
        valid_n    = instr_valid;
        load_err_n = load_en & (state == FETCH_RUN);

        case (state)
            FETCH_LOAD, FETCH_HALT: begin
                valid_n = 1'b0;
                if (start) begin
                    state_n = FETCH_RUN;
                    pc_n    = {RESET_PC[ADDR_W-1:2], 2'b00};
                    nop_n   = '0;
                end
            end
            FETCH_RUN: begin
                if (redirect_en) begin
                    pc_n    = {redirect_pc[ADDR_W-1:2], 2'b00};
                    valid_n = 1'b0;
                    nop_n   = '0;
                end else if (!instr_valid) begin
                    out_n    = rd_word;
                    out_pc_n = pc;
                    valid_n  = 1'b1;
                end else if (instr_ready) begin
                    if (instr_out == MIPS_NOP) begin
                        nop_n = (nop_cnt == NOP_MAX) ? nop_cnt : nop_cnt + NOP_W'(1);
                    end else begin
                        nop_n = '0;
                    end
                    if (instr_out == MIPS_NOP && nop_cnt >= NOP_LAST) begin
                        state_n = FETCH_HALT;
                        valid_n = 1'b0;
                    end else begin
                        pc_n     = pc_plus4;
                        out_n    = rd_word;
                        out_pc_n = pc_plus4;
                        valid_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = FETCH_LOAD;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule
